// File: rtl/t05_hdr_pkg.sv
// Shared types and the zero-count rule for the header serializer and the
// codebook synthesis models.
package t05_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ZEROS = 2'd2,
        DONE  = 2'd3
    } hdr_state_t;

    localparam int ZCNT_W = 2;

    // The caller passes the sum-node flags (MSBs of least1/least2) and whether
    // the char equals the low bits of least2.
    function automatic logic [ZCNT_W-1:0] zero_count(
        input logic l1_sum,
        input logic l2_sum,
        input logic char_match
    );
        if (!l1_sum && !l2_sum && char_match) begin
            return 2'd2;
        end else if (l1_sum ^ l2_sum) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

endpackage

// File: rtl/t05_hdr_fifo.sv
// Synchronous token FIFO; pointers wrap modulo DEPTH (a power of two).
module t05_hdr_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/t05_header_serializer.sv
// Queues {char, zero count} tokens and shifts each out as 1, char bits, 0..2
// zeros over a per-bit valid/ready handshake, pulsing write_finish per token.
module t05_header_serializer
    import t05_hdr_pkg::*;
#(
    parameter int CHAR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       char_found,
    input  logic [CHAR_W-1:0]          char_index,
    input  logic [CHAR_W:0]            least1,
    input  logic [CHAR_W:0]            least2,
    output logic                       in_ready,
    output logic                       bit_out,
    output logic                       bit_valid,
    input  logic                       bit_ready,
    output logic                       write_finish,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);

    localparam int TOK_W = CHAR_W + ZCNT_W;
    localparam int BIT_W = $clog2(CHAR_W+2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAR_W);
    localparam logic [BIT_W-1:0] SAT_BIT  = BIT_W'(CHAR_W+1);

    // Handshake: a bit transfers on a rising clk edge where bit_valid and
    // bit_ready are both high; bit_valid/bit_out are registers only, so they
    // never depend combinationally on bit_ready and hold steady while stalled.

    hdr_state_t          state;
    logic [CHAR_W:0]     shreg;
    logic [BIT_W-1:0]    bitcnt;
    logic [ZCNT_W-1:0]   zcnt;

    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [TOK_W-1:0]    din;
    logic [TOK_W-1:0]    dout;
    logic [ZCNT_W-1:0]   push_zcnt;
    logic [CHAR_W-1:0]   pop_char;
    logic [ZCNT_W-1:0]   pop_zcnt;
    logic [CHAR_W-1:0]   load_char;
    logic                unused_least1;

    // Only the sum-node flag of least1 matters for the zero count.
    assign unused_least1 = ^least1[CHAR_W-1:0];

    assign push_zcnt = zero_count(least1[CHAR_W], least2[CHAR_W],
                                  char_index == least2[CHAR_W-1:0]);
    assign din       = {push_zcnt, char_index};
    assign in_ready  = !full;
    assign push      = char_found && !full;
    assign pop       = (state == IDLE) && !empty;
    assign pop_char  = dout[CHAR_W-1:0];
    assign pop_zcnt  = dout[TOK_W-1:CHAR_W];
    assign busy      = (state != IDLE) || !empty;

    generate
        if (LSB_FIRST != 0) begin : g_rev
            always_comb begin
                load_char = '0;
                for (int i = 0; i < CHAR_W; i++) begin
                    load_char[i] = pop_char[CHAR_W-1-i];
                end
            end
        end else begin : g_fwd
            assign load_char = pop_char;
        end
    endgenerate

    t05_hdr_fifo #(
        .WIDTH (TOK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (char_found && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bitcnt       <= '0;
            zcnt         <= '0;
            bit_valid    <= 1'b0;
            bit_out      <= 1'b0;
            write_finish <= 1'b0;
        end else begin
            write_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg     <= {1'b1, load_char};
                        bitcnt    <= '0;
                        zcnt      <= pop_zcnt;
                        bit_valid <= 1'b1;
                        bit_out   <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_ready) begin
                        shreg <= {shreg[CHAR_W-1:0], 1'b0};
                        if (bitcnt != SAT_BIT) begin
                            bitcnt <= bitcnt + BIT_W'(1);
                        end
                        if (bitcnt == LAST_BIT) begin
                            bit_out <= 1'b0;
                            if (zcnt != '0) begin
                                state <= ZEROS;
                            end else begin
                                bit_valid    <= 1'b0;
                                write_finish <= 1'b1;
                                state        <= DONE;
                            end
                        end else begin
                            // bit_out mirrors the MSB of the shifted register.
                            bit_out <= shreg[CHAR_W-1];
                        end
                    end
                end
                ZEROS: begin
                    if (bit_ready) begin
                        zcnt <= zcnt - ZCNT_W'(1);
                        if (zcnt == ZCNT_W'(1)) begin
                            bit_valid    <= 1'b0;
                            write_finish <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
